// File: rtl/ff_event_logger.sv
// ff_event_logger: captures hit samples from the registered-OR stage into a
// small first-word-fall-through FIFO, keeps saturating hit/drop counters and
// raises a threshold interrupt through a three-state FSM.
// Optional feature macro: EVT_LOG_TIMESTAMP_EN adds a free-running timestamp
// counter and stores the timestamp with every FIFO entry. Without it out_ts is 0.
module ff_event_logger #(
  parameter int DEPTH  = 4,
  parameter int THRESH = 4,
  parameter int TS_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_hit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             hit_count,
  output logic [7:0]              drop_cnt,
  input  logic                    cnt_clr,
  output logic                    irq,
  input  logic                    irq_ack
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(THRESH + 1);

  typedef enum logic [1:0] {S_DIS, S_ARM, S_FIRE} state_t;

  state_t          r_state, w_state_nxt;
  logic [WW-1:0]   r_win, w_win_nxt, w_win_inc;
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic [7:0]      r_data [DEPTH];
  logic [15:0]     r_hit_cnt;
  logic [7:0]      r_drop_cnt;
  logic            w_hit, w_pop, w_push, w_full, w_empty;

  assign w_hit   = en && in_valid && in_hit;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same index with opposite wrap bits means the writer lapped the reader.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = w_hit && (!w_full || w_pop);

  assign out_valid = !w_empty;
  assign out_data  = r_data[r_rd_ptr[AW-1:0]];
  assign level     = r_wr_ptr - r_rd_ptr;
  assign hit_count = r_hit_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign irq       = (r_state == S_FIRE);

  // FIFO pointers and data storage; reset clears storage so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr[AW-1:0]] <= in_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef EVT_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ts_mem [DEPTH];

  assign out_ts = r_ts_mem[r_rd_ptr[AW-1:0]];

  // Free-running timestamp, independent of en; captured alongside each push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
      for (int i = 0; i < DEPTH; i++) r_ts_mem[i] <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_push) r_ts_mem[r_wr_ptr[AW-1:0]] <= r_ts;
    end
  end
`else
  assign out_ts = '0;
`endif

  // Saturating counters; clear takes precedence over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_hit && !w_push && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Interrupt FSM state and window counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_DIS;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
    end
  end

  assign w_win_inc = r_win + WW'(1);

  // Next state: en low dominates; in FIRED an ack re-arms, counting a coincident hit.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    if (!en) begin
      w_state_nxt = S_DIS;
      w_win_nxt   = '0;
    end else begin
      case (r_state)
        S_DIS: begin
          w_state_nxt = S_ARM;
          w_win_nxt   = '0;
        end
        S_ARM: begin
          if (w_hit) begin
            w_win_nxt = w_win_inc;
            if (w_win_inc == WW'(THRESH)) w_state_nxt = S_FIRE;
          end
        end
        S_FIRE: begin
          if (irq_ack) begin
            w_state_nxt = S_ARM;
            w_win_nxt   = w_hit ? WW'(1) : '0;
          end
        end
        default: begin
          w_state_nxt = S_DIS;
          w_win_nxt   = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ff_event_logger.sv
// Directed + random bench for ff_event_logger with a queue-based reference model.
module tb_ff_event_logger;
  localparam int DEPTH  = 4;
  localparam int THRESH = 4;
  localparam int TS_W   = 4;

  logic clk = 1'b0;
  logic rst, en, in_valid, in_hit, out_ready, cnt_clr, irq_ack;
  logic [7:0] in_data;
  logic out_valid, irq;
  logic [7:0] out_data, drop_cnt;
  logic [TS_W-1:0] out_ts;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] hit_count;

  ff_event_logger #(.DEPTH(DEPTH), .THRESH(THRESH), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_hit(in_hit), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ts(out_ts), .level(level), .hit_count(hit_count),
    .drop_cnt(drop_cnt), .cnt_clr(cnt_clr), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {ts, data}, plain integer counters.
  logic [TS_W+7:0] q[$];
  int  m_hits, m_drops, m_win, m_ts;
  bit  m_act, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hits = 0; m_drops = 0; m_win = 0; m_ts = 0;
    m_act = 0; m_irq = 0;
  endtask

  task automatic model_edge();
    bit hit, pop;
    hit = en && in_valid && in_hit;
    pop = (q.size() != 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (cnt_clr) begin
      m_hits = 0; m_drops = 0;
    end else if (hit) begin
      if (m_hits < 65535) m_hits++;
      if (q.size() >= DEPTH && m_drops < 255) m_drops++;
    end
    if (hit && q.size() < DEPTH) q.push_back({TS_W'(m_ts), in_data});
    m_ts = (m_ts + 1) % (1 << TS_W);
    if (!en) begin
      m_act = 0; m_irq = 0; m_win = 0;
    end else if (!m_act) begin
      m_act = 1; m_win = 0;
    end else if (m_irq) begin
      if (irq_ack) begin m_irq = 0; m_win = hit ? 1 : 0; end
    end else if (hit) begin
      m_win++;
      if (m_win == THRESH) m_irq = 1;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    chk("irq", 32'(irq), 32'(m_irq));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0][7:0]));
`ifdef EVT_LOG_TIMESTAMP_EN
      chk("out_ts", 32'(out_ts), 32'(q[0][TS_W+7:8]));
`else
      chk("out_ts", 32'(out_ts), 32'(0));
`endif
    end
  endtask

  // Drive inputs away from the edge, advance model and DUT, then compare.
  task automatic step(input logic e, input logic v, input logic h, input logic [7:0] d,
                      input logic rdy, input logic ack, input logic clr);
    en = e; in_valid = v; in_hit = h; in_data = d;
    out_ready = rdy; irq_ack = ack; cnt_clr = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 0; in_valid = 0; in_hit = 0; in_data = 0;
    out_ready = 0; irq_ack = 0; cnt_clr = 0;
    model_reset();
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ts", 32'(out_ts), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_drops", 32'(drop_cnt), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    #1;

    // Push latency / ordering with consumer always ready.
    step(1, 0, 0, 8'h00, 1, 0, 0);
    step(1, 1, 1, 8'hFF, 1, 0, 0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'hFF);
    step(1, 1, 1, 8'hFF, 1, 0, 0);
    step(1, 1, 1, 8'hFF, 1, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 0);
    chk("lat_drained", 32'(out_valid), 0);

    // Overflow: six hits into a stalled FIFO.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 8'(8'h10 + i), 0, 0, 0);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_drops", 32'(drop_cnt), 2);
    chk("ovf_hits", 32'(hit_count), 9);
    chk("ovf_head", 32'(out_data), 32'h10);

    // Full FIFO with simultaneous pop accepts the new sample.
    step(1, 1, 1, 8'hA5, 1, 0, 0);
    chk("fpp_level", 32'(level), 4);
    chk("fpp_drops", 32'(drop_cnt), 2);
    chk("fpp_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 1, 0, 0);
    chk("fpp_empty", 32'(level), 0);

    // Interrupt sequence from a clean arm.
    step(0, 0, 0, 8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'(i), 1, 0, 0);
    chk("irq_pre", 32'(irq), 0);
    step(1, 1, 1, 8'h33, 1, 0, 0);
    chk("irq_fire", 32'(irq), 1);
    step(1, 1, 1, 8'h44, 1, 0, 0);
    chk("irq_hold", 32'(irq), 1);
    step(1, 0, 0, 8'h00, 1, 1, 0);
    chk("irq_ack", 32'(irq), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'(i), 1, 0, 0);
    chk("irq_refire", 32'(irq), 1);
    step(0, 0, 0, 8'h00, 1, 0, 0);
    chk("irq_dis", 32'(irq), 0);

    // Clear wins over a coincident hit.
    step(1, 1, 1, 8'h55, 1, 0, 0);
    step(1, 1, 1, 8'h66, 1, 0, 1);
    chk("clr_hits", 32'(hit_count), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(9) != 0), 1'($urandom_range(1)), 1'($urandom_range(3) != 0),
           8'($urandom), 1'($urandom_range(2) == 0), 1'($urandom_range(4) == 0),
           1'($urandom_range(30) == 0));

    // Asynchronous reset with three entries queued.
    step(0, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'(8'hC0 + i), 0, 0, 0);
    chk("ar_level_pre", 32'(level), 3);
    rst = 1'b1;
    #2;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_level", 32'(level), 0);
    chk("ar_irq", 32'(irq), 0);
    chk("ar_hits", 32'(hit_count), 0);
    chk("ar_drops", 32'(drop_cnt), 0);
    model_reset();
    rst = 1'b0;

    // Timestamp wrap: hits captured at ts 15 and then 0.
    step(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 40 && m_ts != 15; i++) step(1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 1, 8'h0F, 0, 0, 0);
    step(1, 1, 1, 8'hF0, 0, 0, 0);
`ifdef EVT_LOG_TIMESTAMP_EN
    chk("ts_first", 32'(out_ts), 15);
`else
    chk("ts_first", 32'(out_ts), 0);
`endif
    step(1, 0, 0, 8'h00, 1, 0, 0);
    chk("ts_wrap", 32'(out_ts), 0);
    chk("ts_wrap_data", 32'(out_data), 32'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
